mmio_bus_ctrl: RTL and testbench
================================

Name: mmio_bus_ctrl

Overview:
- Parametrised successor to the console's fixed word-only memory controller.
- Bridges the RV32 core's single memory port to N_SLAVES memory-mapped slaves (ROM, RAM, keyboard, display, future timers/audio).
- Adds byte/halfword/word access with lane steering and sign/zero extension, variable-latency slaves via a ready handshake, and bus-error reporting for misalignment, unmapped regions and slave timeout.

Parameters:
- N_SLAVES, 4: number of slave regions; 1..16.
- REGION_SHIFT, 28: slave index is cpu_addr[REGION_SHIFT+3:REGION_SHIFT].
- SLV_ADDR_W, 16: width of the address forwarded to slaves.
- TIMEOUT, 15: maximum ACCESS cycles before a bus error; 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data, right-aligned
- cpu_size  in  3  [2] = unsigned load; [1:0]: 00 = byte, 01 = half, 10 = word, 11 = illegal
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  extended load data, valid with cpu_ready
- cpu_err  out  1  bus error, valid with cpu_ready
- busy  out  1  high whenever state is not IDLE
- s_req  out  N_SLAVES  one-hot request, held until ready or timeout
- s_we  out  1  write enable to the selected slave
- s_addr  out  SLV_ADDR_W  {cpu_addr[SLV_ADDR_W-1:2], 2'b00}
- s_wdata  out  32  lane-replicated write data
- s_be  out  4  byte enables; all zero on reads
- s_ready  in  N_SLAVES  per-slave completion
- s_rdata  in  32*N_SLAVES  slave i occupies bits [32i+31:32i]

Behaviour:
- **Reset.** rst high forces IDLE immediately, regardless of the current state.
  - cpu_ready = 0, cpu_err = 0, cpu_rdata = 0, busy = 0.
  - s_req = 0, s_we = 0, s_addr = 0, s_wdata = 0, s_be = 0.
  - Timeout counter = 0.
  - A reset during ACCESS abandons the transfer: no cpu_ready pulse, s_req drops asynchronously.
- **IDLE.** On cpu_req = 1, register addr, we, size, wdata and off = cpu_addr[1:0], then check for errors:
  - Error if size = 11.
  - Error if half access with off[0] = 1.
  - Error if word access with off != 0.
  - Error if the slave index is >= N_SLAVES.
  - On error, go to RESP with err = 1. No s_req is issued and slaves see nothing.
  - Otherwise go to ACCESS with s_req[idx] = 1 and the counter cleared.
- **Write lane steering.**
  - Byte: s_wdata = {4{wdata[7:0]}}, s_be = 4'b0001 << off.
  - Half: s_wdata = {2{wdata[15:0]}}, s_be = 4'b0011 << off.
  - Word: s_wdata = wdata, s_be = 4'b1111.
- **ACCESS.** Outputs are held stable.
  - If s_ready[idx] = 1: capture rdata_sel = s_rdata[idx], drop s_req, go to RESP with err = 0.
  - Else, if counter == TIMEOUT - 1: drop s_req, go to RESP with err = 1.
  - Else: increment the counter.
  - s_ready from a non-selected slave is ignored, as is any s_ready seen outside ACCESS.
- **RESP.** cpu_ready = 1 for exactly one cycle, then return to IDLE.
  - cpu_req asserted in RESP is ignored; the CPU re-issues in IDLE.
  - Reads: sh = rdata_sel >> (8*off).
    - Byte: low 8 bits of sh, zero-extended if size[2] = 1, else sign-extended from bit 7.
    - Half: low 16 bits of sh, extended the same way from bit 15.
    - Word: sh unchanged.
  - Writes and errors: cpu_rdata = 0.
  - cpu_rdata and cpu_err return to 0 after the pulse.
- **Latency** (cycle 0 = cpu_req sampled in IDLE):
  - Zero-wait slave (s_ready high in cycle 1): cpu_ready in cycle 2.
  - Each wait cycle adds 1.
  - Decode/alignment error: cpu_ready + err in cycle 1.
  - Timeout: cpu_ready + err in cycle TIMEOUT + 1.
- **Outputs.** All are registered with no combinational path from cpu_* to s_*, so the bridge is safe across the two-clock console boundary when slaves synchronise internally.

Test Plan:
- **Zero-wait word read.** Slave 1 ties s_ready high with s_rdata[63:32] = 32'hDEADBEEF; read word at 32'h1000_0004. Required:
  - s_req = 4'b0010 and s_addr = 16'h0004 in cycle 1.
  - cpu_ready with cpu_rdata = 32'hDEADBEEF, err = 0 in cycle 2.
- **Byte loads with 3 wait states.** Slave 0 returns 32'h80FF_7F01; lb at offset 3, then lbu at offset 3. Required:
  - lb: cpu_rdata = 32'hFFFF_FF80.
  - lbu: 32'h0000_0080.
  - cpu_ready in cycle 5 for each.
- **Halfword store.** sh wdata = 32'h1234_ABCD at offset 2. Required: s_wdata = 32'hABCD_ABCD, s_be = 4'b1100, s_we = 1.
- **Misaligned and unmapped.** Word read at 32'h2000_0002, then a read at 32'h5000_0000 with N_SLAVES = 4. Required for each:
  - cpu_ready + cpu_err in cycle 1.
  - s_req stays 0 throughout.
- **Timeout.** With TIMEOUT = 15, slave 2 never asserts ready. Required:
  - s_req[2] high for cycles 1..15.
  - cpu_ready + cpu_err in cycle 16.
  - busy low in cycle 17.
- **Reset mid-access.** Assert rst in cycle 3 of an ACCESS to slave 3. Required:
  - s_req, busy and cpu_ready drop immediately.
  - No stale cpu_ready pulse after rst is released.
  - The next request completes normally.

Source files
------------

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: bridges the RV32 core's single memory port to N_SLAVES
// memory-mapped slaves with byte/half/word lane steering, load extension,
// a ready handshake for variable-latency slaves and bus-error reporting
// (misalignment, unmapped region, slave timeout).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_req/we/addr/    CPU request (sampled only when idle); cpu_size[2]
//   wdata/size            selects unsigned loads, [1:0] = byte/half/word
//   cpu_ready/rdata/err one-cycle completion pulse with extended load data
//   busy                high while a transfer is in progress
//   s_req               one-hot slave request, held until ready or timeout
//   s_we/addr/wdata/be  word-aligned address, lane-replicated data, enables
//   s_ready, s_rdata    per-slave completion and read data (32 bits each)
module mmio_bus_ctrl #(
  parameter int N_SLAVES     = 4,
  parameter int REGION_SHIFT = 28,
  parameter int SLV_ADDR_W   = 16,
  parameter int TIMEOUT      = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [2:0]               cpu_size,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_err,
  output logic                     busy,
  output logic [N_SLAVES-1:0]      s_req,
  output logic                     s_we,
  output logic [SLV_ADDR_W-1:0]    s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_be,
  input  logic [N_SLAVES-1:0]      s_ready,
  input  logic [32*N_SLAVES-1:0]   s_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t                  state_q, state_d;
  logic [N_SLAVES-1:0]     s_req_q, s_req_d;
  logic                    s_we_q, s_we_d;
  logic [SLV_ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [31:0]             s_wdata_q, s_wdata_d;
  logic [3:0]              s_be_q, s_be_d;
  logic [3:0]              idx_q, idx_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              off_q, off_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    cpu_ready_q, cpu_ready_d;
  logic                    cpu_err_q, cpu_err_d;
  logic [31:0]             cpu_rdata_q, cpu_rdata_d;
  logic                    busy_q, busy_d;

  logic [3:0]  idx_in;
  logic        err_in;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic [31:0] sh;
  logic [31:0] load_ext;
  logic        unused_addr;

  assign unused_addr = ^cpu_addr;
  assign idx_in      = cpu_addr[REGION_SHIFT+3:REGION_SHIFT];

  always_comb begin
    err_in = 1'b0;
    if (cpu_size[1:0] == 2'b11) err_in = 1'b1;
    if (cpu_size[1:0] == 2'b01 && cpu_addr[0]) err_in = 1'b1;
    if (cpu_size[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00) err_in = 1'b1;
    if ({1'b0, idx_in} >= 5'(N_SLAVES)) err_in = 1'b1;
  end

  // Mux the registered slave index; indices past N_SLAVES never reach ACCESS.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // Extension is applied on capture so cpu_rdata stays a plain register.
  always_comb begin
    sh = sel_rdata >> {off_q, 3'b000};
    case (size_q[1:0])
      2'b00:   load_ext = size_q[2] ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_ext = size_q[2] ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    s_req_d     = s_req_q;
    s_we_d      = s_we_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_be_d      = s_be_q;
    idx_d       = idx_q;
    size_d      = size_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    cpu_ready_d = 1'b0;
    cpu_err_d   = 1'b0;
    cpu_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          idx_d  = idx_in;
          size_d = cpu_size;
          off_d  = cpu_addr[1:0];
          if (err_in) begin
            state_d     = ST_RESP;
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
          end else begin
            state_d  = ST_ACCESS;
            cnt_d    = '0;
            s_we_d   = cpu_we;
            s_addr_d = {cpu_addr[SLV_ADDR_W-1:2], 2'b00};
            for (int unsigned i = 0; i < N_SLAVES; i++) begin
              s_req_d[i] = (idx_in == 4'(i));
            end
            case (cpu_size[1:0])
              2'b00: begin
                s_wdata_d = {4{cpu_wdata[7:0]}};
                s_be_d    = 4'b0001 << cpu_addr[1:0];
              end
              2'b01: begin
                s_wdata_d = {2{cpu_wdata[15:0]}};
                s_be_d    = 4'b0011 << cpu_addr[1:0];
              end
              default: begin
                s_wdata_d = cpu_wdata;
                s_be_d    = 4'b1111;
              end
            endcase
            if (!cpu_we) s_be_d = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d     = ST_RESP;
          s_req_d     = '0;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = s_we_q ? '0 : load_ext;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          s_req_d     = '0;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_req_q     <= '0;
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_be_q      <= '0;
      idx_q       <= '0;
      size_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_req_q     <= s_req_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_be_q      <= s_be_d;
      idx_q       <= idx_d;
      size_q      <= size_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign busy      = busy_q;
  assign s_req     = s_req_q;
  assign s_we      = s_we_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_be      = s_be_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
module tb_mmio_bus_ctrl;
  localparam int N       = 4;
  localparam int TMO     = 15;
  localparam int NEVER   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [2:0]  cpu_size = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        busy;
  logic [N-1:0] s_req;
  logic        s_we;
  logic [15:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [N-1:0] s_ready = '0;
  logic [32*N-1:0] s_rdata;

  logic [31:0] slv_word [N];
  int          wait_cyc [N];
  int          hold     [N];
  logic        noise_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  assign s_rdata = {slv_word[3], slv_word[2], slv_word[1], slv_word[0]};

  mmio_bus_ctrl #(.N_SLAVES(N), .REGION_SHIFT(28), .SLV_ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .busy(busy), .s_req(s_req),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  // Slave models: ready after wait_cyc[i] cycles of request; idle slaves may toggle ready.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (s_req[i]) begin
        s_ready[i] = (wait_cyc[i] != NEVER) && (hold[i] >= wait_cyc[i]);
        hold[i]++;
      end else begin
        hold[i] = 0;
        s_ready[i] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic ref_dec_err(input logic [31:0] a, input logic [2:0] sz);
    int region = int'(a >> 28);
    if (sz[1:0] == 2'b11) return 1'b1;
    if (sz[1:0] == 2'b01 && (a % 2) != 0) return 1'b1;
    if (sz[1:0] == 2'b10 && (a % 4) != 0) return 1'b1;
    return region >= N;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input logic [2:0] sz);
    logic [31:0] v = w >> (8 * off);
    if (sz[1:0] == 2'b00) begin
      v = v % 256;
      if (!sz[2] && v >= 128) v = v - 256;
    end else if (sz[1:0] == 2'b01) begin
      v = v % 65536;
      if (!sz[2] && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input int off, input logic [2:0] sz);
    if (sz[1:0] == 2'b00) return 4'(1 << off);
    if (sz[1:0] == 2'b01) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] sz);
    if (sz[1:0] == 2'b00) return (d % 256) * 32'h0101_0101;
    if (sz[1:0] == 2'b01) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic int ref_latency(input logic dec_err, input int wt);
    if (dec_err) return 1;
    if (wt >= TMO) return TMO + 1;
    return wt + 2;
  endfunction

  // ---------------- transaction driver (observes only) ----------------
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, output int lat, output logic err,
                         output logic [31:0] rdata, output logic [3:0] req1,
                         output logic [15:0] addr1, output logic [31:0] wdata1,
                         output logic [3:0] be1, output logic we1, output int req_cycles);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_size = size;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    lat = -1; err = 1'b0; rdata = '0; req_cycles = 0;
    req1 = '0; addr1 = '0; wdata1 = '0; be1 = '0; we1 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req1 = s_req; addr1 = s_addr; wdata1 = s_wdata; be1 = s_be; we1 = s_we;
      end
      if (s_req != '0) req_cycles++;
      if (cpu_ready) begin
        lat = c; err = cpu_err; rdata = cpu_rdata;
        break;
      end
    end
  endtask

  int          lat, rc;
  logic        err, we1;
  logic [31:0] rdata, wd1;
  logic [3:0]  req1, be1;
  logic [15:0] a1;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cpu_ready, cpu_err, busy, s_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {cpu_ready, cpu_err, busy, s_we});
    end
    n_tests++;
    if ({cpu_rdata, s_wdata, s_addr, s_be, s_req} !== '0) begin
      n_fail++; $display("FAIL reset_data rdata=%h wdata=%h addr=%h be=%b req=%b want all 0",
                         cpu_rdata, s_wdata, s_addr, s_be, s_req);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_read();
    slv_word[1] = 32'hDEADBEEF; wait_cyc[1] = 0;
    run_txn(1'b0, 32'h1000_0004, '0, 3'b010, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
    n_tests++; if (req1 !== 4'b0010) begin n_fail++; $display("FAIL zw_sreq got %b want 0010", req1); end
    n_tests++; if (a1 !== 16'h0004) begin n_fail++; $display("FAIL zw_saddr got %h want 0004", a1); end
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL zw_latency got %0d want 2", lat); end
    n_tests++; if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
      n_fail++; $display("FAIL zw_data got %h err=%b want deadbeef err=0", rdata, err);
    end
  endtask

  task automatic test_byte_wait();
    slv_word[0] = 32'h80FF_7F01; wait_cyc[0] = 3;
    run_txn(1'b0, 32'h0000_0003, '0, 3'b000, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
    n_tests++; if (rdata !== 32'hFFFF_FF80 || lat !== 5) begin
      n_fail++; $display("FAIL lb got %h lat %0d want ffffff80 lat 5", rdata, lat);
    end
    run_txn(1'b0, 32'h0000_0003, '0, 3'b100, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
    n_tests++; if (rdata !== 32'h0000_0080 || lat !== 5) begin
      n_fail++; $display("FAIL lbu got %h lat %0d want 00000080 lat 5", rdata, lat);
    end
  endtask

  task automatic test_half_store();
    wait_cyc[0] = 1;
    run_txn(1'b1, 32'h0000_0002, 32'h1234_ABCD, 3'b001, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
    n_tests++; if (wd1 !== 32'hABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata got %h want abcdabcd", wd1); end
    n_tests++; if (be1 !== 4'b1100 || we1 !== 1'b1) begin
      n_fail++; $display("FAIL sh_be got be=%b we=%b want 1100 1", be1, we1);
    end
    n_tests++; if (lat !== 3 || err !== 1'b0 || rdata !== '0) begin
      n_fail++; $display("FAIL sh_resp got lat %0d err %b rdata %h want 3 0 0", lat, err, rdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{32'h2000_0002, 32'h5000_0000, 32'h1000_0000};
    logic [2:0]  sizes [3] = '{3'b010, 3'b010, 3'b011};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, addrs[i], '0, sizes[i], lat, err, rdata, req1, a1, wd1, be1, we1, rc);
      n_tests++; if (lat !== 1 || err !== 1'b1) begin
        n_fail++; $display("FAIL err%0d_resp got lat %0d err %b want 1 1", i, lat, err);
      end
      n_tests++; if (rc !== 0) begin n_fail++; $display("FAIL err%0d_sreq got %0d req cycles want 0", i, rc); end
    end
  endtask

  task automatic test_timeout();
    wait_cyc[2] = NEVER;
    run_txn(1'b0, 32'h2000_0000, '0, 3'b010, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
    n_tests++; if (req1 !== 4'b0100 || rc !== TMO) begin
      n_fail++; $display("FAIL tmo_sreq got req %b for %0d cycles want 0100 for %0d", req1, rc, TMO);
    end
    n_tests++; if (lat !== TMO + 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL tmo_resp got lat %0d err %b want %0d 1", lat, err, TMO + 1);
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b want 0", busy); end
    // Last cycle before the limit still completes successfully.
    wait_cyc[2] = TMO - 1; slv_word[2] = 32'h0BAD_F00D;
    run_txn(1'b0, 32'h2000_0000, '0, 3'b010, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
    n_tests++; if (lat !== TMO + 1 || err !== 1'b0 || rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL tmo_edge got lat %0d err %b rdata %h want %0d 0 0badf00d", lat, err, rdata, TMO + 1);
    end
  endtask

  task automatic test_reset_mid_access();
    int stale = 0;
    wait_cyc[3] = NEVER;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000_0000; cpu_size = 3'b010;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if ({s_req, busy, cpu_ready} !== '0) begin
      n_fail++; $display("FAIL midrst_drop got req %b busy %b ready %b want 0", s_req, busy, cpu_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_ready) stale++;
    end
    n_tests++; if (stale !== 0) begin n_fail++; $display("FAIL midrst_stale got %0d pulses want 0", stale); end
    wait_cyc[3] = 1; slv_word[3] = 32'h7654_3210;
    run_txn(1'b0, 32'h3000_0000, '0, 3'b010, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
    n_tests++; if (lat !== 3 || err !== 1'b0 || rdata !== 32'h7654_3210) begin
      n_fail++; $display("FAIL midrst_next got lat %0d err %b rdata %h want 3 0 76543210", lat, err, rdata);
    end
  endtask

  task automatic test_random();
    noise_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      logic [31:0] addr, wd, exp_rd;
      logic [2:0]  sz;
      logic        we, derr, exp_err;
      int          region, r, wt, exp_lat;
      region = $urandom_range(0, 5);
      addr = {4'(region), 28'($urandom)};
      wd = $urandom;
      sz = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      wt = (r < 6) ? r : (r == 6) ? TMO - 1 : (r == 7) ? TMO : NEVER;
      if (region < N) begin
        wait_cyc[region] = wt;
        slv_word[region] = $urandom;
      end
      derr = ref_dec_err(addr, sz);
      exp_lat = ref_latency(derr, wt);
      exp_err = derr || (wt >= TMO);
      exp_rd = (exp_err || we) ? 32'h0 : ref_load(slv_word[region], int'(addr % 4), sz);
      run_txn(we, addr, wd, sz, lat, err, rdata, req1, a1, wd1, be1, we1, rc);
      n_tests++;
      if (lat !== exp_lat || err !== exp_err || rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rnd%0d_resp addr %h sz %b we %b: got lat %0d err %b rdata %h want %0d %b %h",
                 t, addr, sz, we, lat, err, rdata, exp_lat, exp_err, exp_rd);
      end
      if (!derr) begin
        n_tests++;
        if (req1 !== 4'(1 << region) || a1 !== 16'(addr & 32'hFFFC) || we1 !== we ||
            be1 !== (we ? ref_be(int'(addr % 4), sz) : 4'h0) ||
            (we && wd1 !== ref_wdata(wd, sz))) begin
          n_fail++;
          $display("FAIL rnd%0d_bus got req %b addr %h we %b be %b wdata %h (addr %h sz %b wd %h)",
                   t, req1, a1, we1, be1, wd1, addr, sz, wd);
        end
      end
    end
    noise_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      slv_word[i] = '0; wait_cyc[i] = 0;
    end
    test_reset();
    test_zero_wait_read();
    test_byte_wait();
    test_half_store();
    test_errors();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
